// File: rtl/sweep_ctrl_if.sv
// Connection bundle between the sweep sequencer and its environment: the
// control handshake, the bounds, the counter drive/feedback and the status.
// The slave modport is the sequencer's view; master is the environment's.
interface sweep_ctrl_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned PCNT_W = 16
);
    logic              start;
    logic              stop;
    logic              mode;
    logic [WIDTH-1:0]  lo;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  count;
    logic              load;
    logic [WIDTH-1:0]  data;
    logic              u_d;
    logic              busy;
    logic              period_done;
    logic              cfg_err;
    logic [PCNT_W-1:0] period_cnt;

    modport master (
        output start, stop, mode, lo, hi, count,
        input  load, data, u_d, busy, period_done, cfg_err, period_cnt
    );

    modport slave (
        input  start, stop, mode, lo, hi, count,
        output load, data, u_d, busy, period_done, cfg_err, period_cnt
    );
endinterface

// File: rtl/sweep_ctrl.sv
// Sequencer for an 8-bit up/down counter without an enable. It steers the
// counter's load/data/u_d so that count sweeps between latched bounds as a
// triangle or a sawtooth, and counts completed periods. While idle the counter
// is held by reloading its own value every cycle.
module sweep_ctrl #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned PCNT_W = 16
) (
    input logic         clk_i,
    input logic         rst_i,
    sweep_ctrl_if.slave sweep
);

    typedef enum logic [1:0] {StIdle, StInit, StUp, StDown} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   lo_q, hi_q;
    logic               mode_q;
    logic [PCNT_W-1:0]  pcnt_q;
    logic               cfg_err_q;

    logic               accept, reject;
    logic               load, u_d, pdone;
    logic [WIDTH-1:0]   data;
    logic               in_range;

    // Feedback outside the latched window means the counter was disturbed.
    assign in_range = (sweep.count >= lo_q) && (sweep.count <= hi_q);

    // Next-state and output decode from state, feedback and latched bounds.
    always_comb begin
        state_d = state_q;
        load    = 1'b1;
        data    = sweep.count;
        u_d     = 1'b1;
        pdone   = 1'b0;
        accept  = 1'b0;
        reject  = 1'b0;
        case (state_q)
            StIdle: begin
                if (sweep.start && !sweep.stop) begin
                    if (sweep.lo <= sweep.hi) begin
                        accept  = 1'b1;
                        state_d = StInit;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            StInit: begin
                data    = lo_q;
                state_d = StUp;
            end
            StUp: begin
                if (lo_q == hi_q) begin
                    // Degenerate window: pin to lo, every cycle is a period.
                    data  = lo_q;
                    pdone = 1'b1;
                end else if (!in_range) begin
                    data = lo_q;
                end else if (sweep.count < hi_q) begin
                    load = 1'b0;
                end else if (!mode_q) begin
                    // Turn around at hi without reloading.
                    load    = 1'b0;
                    u_d     = 1'b0;
                    state_d = StDown;
                end else begin
                    data  = lo_q;
                    pdone = 1'b1;
                end
            end
            StDown: begin
                if (!in_range) begin
                    data    = lo_q;
                    state_d = StUp;
                end else if (sweep.count > lo_q) begin
                    load = 1'b0;
                    u_d  = 1'b0;
                end else begin
                    load    = 1'b0;
                    pdone   = 1'b1;
                    state_d = StUp;
                end
            end
            default: state_d = StIdle;
        endcase
        // Stop overrides everything: freeze the counter and drop to idle.
        if (sweep.stop && (state_q != StIdle)) begin
            state_d = StIdle;
            load    = 1'b1;
            data    = sweep.count;
            u_d     = 1'b1;
            pdone   = 1'b0;
        end
    end

    // State, latched configuration, period counter and error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            lo_q      <= '0;
            hi_q      <= '0;
            mode_q    <= 1'b0;
            pcnt_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= reject;
            if (accept) begin
                lo_q   <= sweep.lo;
                hi_q   <= sweep.hi;
                mode_q <= sweep.mode;
                pcnt_q <= '0;
            end else if (pdone && (pcnt_q != {PCNT_W{1'b1}})) begin
                pcnt_q <= pcnt_q + 1'b1;
            end
        end
    end

    assign sweep.load        = load;
    assign sweep.data        = data;
    assign sweep.u_d         = u_d;
    assign sweep.busy        = (state_q != StIdle);
    assign sweep.period_done = pdone;
    assign sweep.cfg_err     = cfg_err_q;
    assign sweep.period_cnt  = pcnt_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl: two instances (16-bit and 2-bit period counters) each
// closing the loop through a behavioural up/down counter. Expected values come
// from a phase-index model of the sweep waveform.
module tb_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, mode;
    logic [7:0] lo, hi;
    logic [7:0] cnt0, cnt1;

    int n_err = 0;
    int n_checks = 0;

    // Model: phase 0 idle, 1 init, 2 running; k = cycles since count first hit lo.
    int m_phase, m_lo, m_hi, m_k, m_pcnt, m_count;
    bit m_mode, m_err;

    always #5 clk = ~clk;

    sweep_ctrl_if #(.WIDTH(8), .PCNT_W(16)) if0 ();
    sweep_ctrl_if #(.WIDTH(8), .PCNT_W(2))  if1 ();

    sweep_ctrl #(.WIDTH(8), .PCNT_W(16)) dut0 (.clk_i(clk), .rst_i(rst), .sweep(if0.slave));
    sweep_ctrl #(.WIDTH(8), .PCNT_W(2))  dut1 (.clk_i(clk), .rst_i(rst), .sweep(if1.slave));

    assign if0.start = start;
    assign if0.stop  = stop;
    assign if0.mode  = mode;
    assign if0.lo    = lo;
    assign if0.hi    = hi;
    assign if0.count = cnt0;
    assign if1.start = start;
    assign if1.stop  = stop;
    assign if1.mode  = mode;
    assign if1.lo    = lo;
    assign if1.hi    = hi;
    assign if1.count = cnt1;

    // Behavioural counter_u_d for each instance; its active-low reset is ~rst.
    always_ff @(posedge clk) begin
        if (rst)           cnt0 <= 8'd0;
        else if (if0.load) cnt0 <= if0.data;
        else if (if0.u_d)  cnt0 <= cnt0 + 8'd1;
        else               cnt0 <= cnt0 - 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)           cnt1 <= 8'd0;
        else if (if1.load) cnt1 <= if1.data;
        else if (if1.u_d)  cnt1 <= cnt1 + 8'd1;
        else               cnt1 <= cnt1 - 8'd1;
    end

    function automatic int f_count(int k);
        int span = m_hi - m_lo;
        int r;
        if (span == 0) return m_lo;
        if (m_mode) return m_lo + (k % (span + 1));
        r = k % (2 * span);
        return (r <= span) ? m_lo + r : m_lo + 2 * span - r;
    endfunction

    function automatic bit f_pdone(int k);
        int span = m_hi - m_lo;
        if (span == 0) return 1'b1;
        if (m_mode) return (k % (span + 1)) == span;
        return (k > 0) && ((k % (2 * span)) == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: check this cycle's outputs, then advance the model.
    task automatic tick();
        bit hold, pd;
        @(negedge clk);
        hold = (m_phase == 0) || stop;
        pd   = (m_phase == 2) && !stop && f_pdone(m_k);
        if (!rst) begin
            chk("busy", if0.busy, m_phase != 0);
            chk("period_done", if0.period_done, pd);
            chk("cfg_err", if0.cfg_err, m_err);
            chk("period_cnt", if0.period_cnt, (m_pcnt > 65535) ? 65535 : m_pcnt);
            chk("count", cnt0, m_count);
            chk("count_w2", cnt1, m_count);
            chk("busy_w2", if1.busy, m_phase != 0);
            chk("period_cnt_w2", if1.period_cnt, (m_pcnt > 3) ? 3 : m_pcnt);
            if (hold) begin
                chk("hold_load", if0.load, 1);
                chk("hold_data", if0.data, m_count);
                chk("hold_u_d", if0.u_d, 1);
            end else if (m_phase == 1) begin
                chk("init_load", if0.load, 1);
                chk("init_data", if0.data, m_lo);
            end
        end
        @(posedge clk);
        m_err = 1'b0;
        if (rst) begin
            m_phase = 0;
            m_pcnt  = 0;
            m_count = 0;
        end else begin
            case (m_phase)
                0: if (start && !stop) begin
                    if (lo <= hi) begin
                        m_phase = 1;
                        m_lo    = lo;
                        m_hi    = hi;
                        m_mode  = mode;
                        m_pcnt  = 0;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                1: if (stop) m_phase = 0;
                   else begin
                       m_phase = 2;
                       m_k     = 0;
                       m_count = m_lo;
                   end
                default: if (stop) m_phase = 0;
                   else begin
                       if (pd) m_pcnt++;
                       m_k++;
                       m_count = f_count(m_k);
                   end
            endcase
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic go(input bit md, input int l, input int h);
        mode  = md;
        lo    = 8'(l);
        hi    = 8'(h);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        bit found;
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; lo = 8'd0; hi = 8'd0;
        m_phase = 0; m_pcnt = 0; m_count = 0; m_err = 0; m_k = 0;
        m_lo = 0; m_hi = 0; m_mode = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        run(3);

        // Triangle 2..5, then stop at count 4 while descending.
        go(1'b0, 2, 5);
        run(20);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_phase == 2 && m_count == 4 && (m_k % 6) > 3) found = 1'b1;
            else tick();
        end
        chk("reach_down4", found, 1);
        stop = 1'b1; tick(); stop = 1'b0;
        run(12);

        // Sawtooth at the top of the range.
        go(1'b1, 250, 255);
        run(24);
        stop = 1'b1; tick(); stop = 1'b0;

        // Full-range triangle, more than one period.
        go(1'b0, 0, 255);
        run(1030);
        stop = 1'b1; tick(); stop = 1'b0;

        // Degenerate window.
        go(1'b0, 7, 7);
        run(10);
        stop = 1'b1; tick(); stop = 1'b0;
        run(2);

        // Rejected bounds, then start together with stop.
        go(1'b0, 9, 3);
        run(3);
        lo = 8'd1; hi = 8'd6; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        run(3);

        // Reset mid-UP, then a normal sweep; the 2-bit counter saturates.
        go(1'b0, 10, 20);
        run(5);
        rst = 1'b1; tick(); rst = 1'b0;
        run(2);
        go(1'b1, 100, 101);
        run(14);
        stop = 1'b1; tick(); stop = 1'b0;

        // Random sweeps with mid-sweep noise on start/bounds and sporadic stops.
        for (int it = 0; it < 25; it++) begin
            go(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 255));
            for (int c = 0, n = $urandom_range(5, 80); c < n; c++) begin
                start = 1'($urandom_range(0, 1));
                lo    = 8'($urandom_range(0, 255));
                hi    = 8'($urandom_range(0, 255));
                mode  = 1'($urandom_range(0, 1));
                stop  = ($urandom_range(0, 40) == 0);
                tick();
            end
            start = 1'b0;
            stop  = 1'b1; tick(); stop = 1'b0;
            run(2);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
